// File: rtl/sar_ctrl_param_if.sv
// Signal bundle between the SAR controller, the dynamic comparator and the
// capacitive DAC switch drivers. The controller attaches through the slave
// modport; the surrounding logic (or a bench) attaches through the master one.
//
// Handshake: start is sampled only while the controller is idle and En=1;
// once busy, start is ignored. valid is a single-cycle pulse, and D and err
// are updated in that same cycle and hold until the next valid pulse. There
// is no back-pressure: the consumer must take D when valid is high or later.
interface sar_ctrl_param_if #(
   parameter int NBITS = 8
);
   logic             En;
   logic             start;
   logic             cont;
   logic             Op;
   logic             Om;
   logic             sample;
   logic             cmp_en;
   logic             busy;
   logic [NBITS-1:0] B;
   logic [NBITS-1:0] BN;
   logic [NBITS-1:0] D;
   logic             valid;
   logic             err;
   logic [2:0]       state_dbg;

   modport master (
      output En, start, cont, Op, Om,
      input  sample, cmp_en, busy, B, BN, D, valid, err, state_dbg
   );

   modport slave (
      input  En, start, cont, Op, Om,
      output sample, cmp_en, busy, B, BN, D, valid, err, state_dbg
   );
endinterface

// File: rtl/sar_ctrl_param.sv
// Parametrised successive-approximation controller: samples, then resolves
// one bit per comparator decision from MSB to LSB, with optional DAC settling
// cycles, a per-bit decision timeout and a continuous-conversion mode.
module sar_ctrl_param #(
   parameter int NBITS      = 8,
   parameter int SAMPLE_CYC = 1,
   parameter int SETTLE_CYC = 0,
   parameter int TIMEOUT    = 4
) (
   input logic             clk,
   input logic             rst_n,
   sar_ctrl_param_if.slave bus
);
   localparam int SAMP_W = $clog2(SAMPLE_CYC + 1);
   localparam int SETL_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
   localparam int TMO_W  = $clog2(TIMEOUT + 1);
   localparam int IDX_W  = $clog2(NBITS);

   localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMPLE_CYC - 1);
   localparam logic [SETL_W-1:0] SETL_LAST = SETL_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
   localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT);
   localparam logic [IDX_W-1:0]  IDX_TOP   = IDX_W'(NBITS - 1);
   localparam logic [NBITS-1:0]  MSB_ONLY  = {1'b1, {(NBITS-1){1'b0}}};

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SAMPLE  = 3'd1;
   localparam logic [2:0] S_SETTLE  = 3'd2;
   localparam logic [2:0] S_COMPARE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;
   // Where a new trial bit goes: settle first unless settling is disabled.
   localparam logic [2:0] S_TRIAL   = (SETTLE_CYC == 0) ? S_COMPARE : S_SETTLE;

   logic [2:0]       state_q, state_d;
   logic [NBITS-1:0] b_q, b_d;
   logic [NBITS-1:0] d_q, d_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [SAMP_W-1:0] samp_q, samp_d;
   logic [SETL_W-1:0] setl_q, setl_d;
   logic             acc_q, acc_d;
   logic             err_q, err_d;
   logic             valid_q, valid_d;
   logic             sample_q, sample_d;
   logic             cmp_en_q, cmp_en_d;
   logic             busy_q, busy_d;
   logic             decided;
   logic             bit_val;

   // Next-state, trial-code and result computation for the whole conversion.
   always_comb begin
      state_d = state_q;
      b_d     = b_q;
      d_d     = d_q;
      idx_d   = idx_q;
      tmo_d   = tmo_q;
      samp_d  = samp_q;
      setl_d  = setl_q;
      acc_d   = acc_q;
      err_d   = err_q;
      valid_d = 1'b0;
      decided = 1'b0;
      bit_val = 1'b0;
      if (!bus.En) begin
         // Abort: drop to idle, keep the previous result and error flag.
         state_d = S_IDLE;
         b_d     = '0;
         tmo_d   = '0;
         samp_d  = '0;
         setl_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_d = S_SAMPLE;
                  b_d     = '0;
                  samp_d  = '0;
               end
            end
            S_SAMPLE: begin
               if (samp_q == SAMP_LAST) begin
                  samp_d  = '0;
                  setl_d  = '0;
                  tmo_d   = '0;
                  acc_d   = 1'b0;
                  b_d     = MSB_ONLY;
                  idx_d   = IDX_TOP;
                  state_d = S_TRIAL;
               end else begin
                  samp_d = samp_q + 1'b1;
               end
            end
            S_SETTLE: begin
               if (setl_q == SETL_LAST) begin
                  setl_d  = '0;
                  state_d = S_COMPARE;
               end else begin
                  setl_d = setl_q + 1'b1;
               end
            end
            S_COMPARE: begin
               // A stuck comparator resolves the bit to 0 once the limit is hit.
               if (tmo_q == TMO_LIMIT) begin
                  decided = 1'b1;
                  bit_val = 1'b0;
                  acc_d   = 1'b1;
               end else if (bus.Op && !bus.Om) begin
                  decided = 1'b1;
                  bit_val = 1'b1;
               end else if (!bus.Op && bus.Om) begin
                  decided = 1'b1;
                  bit_val = 1'b0;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
               if (decided) begin
                  tmo_d        = '0;
                  b_d[idx_q]   = bit_val;
                  if (idx_q != '0) begin
                     b_d[idx_q - 1'b1] = 1'b1;
                     idx_d   = idx_q - 1'b1;
                     state_d = S_TRIAL;
                  end else begin
                     state_d = S_DONE;
                     valid_d = 1'b1;
                     d_d     = b_d;
                     err_d   = acc_d;
                  end
               end
            end
            S_DONE: begin
               if (bus.cont) begin
                  state_d = S_SAMPLE;
                  samp_d  = '0;
               end else begin
                  state_d = S_IDLE;
                  b_d     = '0;
               end
            end
            default: begin
               state_d = S_IDLE;
               b_d     = '0;
            end
         endcase
      end
      sample_d = (state_d == S_SAMPLE);
      cmp_en_d = (state_d == S_COMPARE);
      busy_d   = (state_d != S_IDLE);
   end

   // State and registered outputs, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         b_q      <= '0;
         d_q      <= '0;
         idx_q    <= '0;
         tmo_q    <= '0;
         samp_q   <= '0;
         setl_q   <= '0;
         acc_q    <= 1'b0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         sample_q <= 1'b0;
         cmp_en_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         b_q      <= b_d;
         d_q      <= d_d;
         idx_q    <= idx_d;
         tmo_q    <= tmo_d;
         samp_q   <= samp_d;
         setl_q   <= setl_d;
         acc_q    <= acc_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
         sample_q <= sample_d;
         cmp_en_q <= cmp_en_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.sample    = sample_q;
   assign bus.cmp_en    = cmp_en_q;
   assign bus.busy      = busy_q;
   assign bus.B         = b_q;
   assign bus.BN        = ~b_q;
   assign bus.D         = d_q;
   assign bus.valid     = valid_q;
   assign bus.err       = err_q;
   assign bus.state_dbg = state_q;
endmodule
